// File: rtl/pipelined_decoder.sv
// pipelined_decoder: one-stage instruction decoder with a valid/ready handshake on both sides.
// Optional register/status scoreboard is enabled by defining DECODER_SCOREBOARD_EN.
module pipelined_decoder #(
   parameter int DATA_WIDTH  = 8,
   parameter int SEL_WIDTH   = 2,
   parameter int INSTR_WIDTH = 16,
   parameter int OP1_POS     = 9,
   parameter int OP2_POS     = 4,
   parameter int PARAM_BITS  = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [INSTR_WIDTH-1:0] instruction_i,
   input  logic [2:0]             status_i,
   input  logic                   wb_valid_i,
   input  logic [SEL_WIDTH-1:0]   wb_sel_i,
   input  logic                   stat_wb_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [4:0]             opcode_o,
   output logic [PARAM_BITS-1:0]  param_o,
   output logic [DATA_WIDTH-1:0]  literal_adr_o,
   output logic [SEL_WIDTH-1:0]   rd_sel1_o,
   output logic [SEL_WIDTH-1:0]   rd_sel2_o,
   output logic [SEL_WIDTH-1:0]   wr_sel_o,
   output logic                   rd_en1_o,
   output logic                   rd_en2_o,
   output logic                   wr_en_o,
   output logic                   sel_reg_in_alu_decoder_o,
   output logic                   cnt_wr_en_o,
   output logic                   add_offset_o,
   output logic                   stat_wr_en_o
);
   localparam int NREG = 1 << SEL_WIDTH;

   typedef struct packed {
      logic [4:0]            opcode;
      logic [PARAM_BITS-1:0] param;
      logic [DATA_WIDTH-1:0] lit;
      logic [SEL_WIDTH-1:0]  rs1, rs2, ws;
      logic                  re1, re2, we, sel, cnt, addo, stw;
   } bundle_t;

   bundle_t                bundle_d, bundle_q;
   logic                   out_valid_q;
   logic [4:0]             opc;
   logic [SEL_WIDTH-1:0]   op1, op2;
   logic [PARAM_BITS-1:0]  prm;
   logic                   cond, is_if, stall, accept;
   logic                   unused_instr;

   assign opc          = instruction_i[INSTR_WIDTH-1 -: 5];
   assign op1          = instruction_i[OP1_POS -: SEL_WIDTH];
   assign op2          = instruction_i[OP2_POS -: SEL_WIDTH];
   assign prm          = instruction_i[PARAM_BITS-1:0];
   assign unused_instr = ^instruction_i;
   assign is_if        = (opc >= 5'h11) && (opc <= 5'h15);

   // Branch condition uses the status present in the acceptance cycle.
   always_comb begin
      case (opc)
         5'h11, 5'h13: cond = status_i[2];
         5'h12:        cond = !status_i[2];
         5'h14:        cond = status_i[1];
         5'h15:        cond = status_i[0];
         default:      cond = 1'b0;
      endcase
   end

   always_comb begin
      bundle_d        = '0;
      bundle_d.opcode = opc;
      bundle_d.param  = prm;
      case (opc)
         5'h01, 5'h02, 5'h03, 5'h04, 5'h06: begin
            bundle_d.re1 = 1'b1;  bundle_d.rs1 = op1;
            bundle_d.re2 = 1'b1;  bundle_d.rs2 = op2;
            bundle_d.we  = 1'b1;  bundle_d.ws  = op1;
            bundle_d.sel = 1'b1;  bundle_d.stw = 1'b1;
         end
         5'h05: begin
            bundle_d.re2 = 1'b1;  bundle_d.rs2 = op2;
            bundle_d.we  = 1'b1;  bundle_d.ws  = op1;
            bundle_d.sel = 1'b1;  bundle_d.stw = 1'b1;
         end
         5'h07, 5'h08: begin
            bundle_d.re1 = 1'b1;  bundle_d.rs1 = op1;
            bundle_d.we  = 1'b1;  bundle_d.ws  = op1;
            bundle_d.sel = 1'b1;  bundle_d.stw = 1'b1;
         end
         5'h09: begin
            bundle_d.we  = 1'b1;  bundle_d.ws  = op1;
         end
         5'h10: begin
            bundle_d.cnt = 1'b1;
            bundle_d.lit = DATA_WIDTH'(prm);
         end
         5'h11, 5'h12, 5'h13, 5'h14, 5'h15: begin
            bundle_d.cnt  = cond;
            bundle_d.addo = cond;
            bundle_d.lit  = DATA_WIDTH'(prm);
         end
         default: ;
      endcase
   end

   assign in_ready_o = (!out_valid_q || out_ready_i) && !stall;
   assign accept     = in_valid_i && in_ready_o;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         bundle_q    <= bundle_d;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef DECODER_SCOREBOARD_EN
   logic [NREG-1:0] pend_q, pend_d;
   logic            spend_q, spend_d;

   // Set after clear so a same-cycle writer keeps its register pending.
   always_comb begin
      pend_d  = pend_q;
      spend_d = spend_q;
      if (wb_valid_i) pend_d[wb_sel_i] = 1'b0;
      if (stat_wb_i)  spend_d = 1'b0;
      if (accept && bundle_d.we)  pend_d[bundle_d.ws] = 1'b1;
      if (accept && bundle_d.stw) spend_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_q  <= '0;
         spend_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         spend_q <= spend_d;
      end
   end

   assign stall = (bundle_d.re1 && pend_q[bundle_d.rs1]) ||
                  (bundle_d.re2 && pend_q[bundle_d.rs2]) ||
                  (is_if && spend_q);
`else
   logic unused_wb;
   assign unused_wb = ^{wb_valid_i, wb_sel_i, stat_wb_i, is_if};
   assign stall     = 1'b0;
`endif

   assign out_valid_o              = out_valid_q;
   assign opcode_o                 = bundle_q.opcode;
   assign param_o                  = bundle_q.param;
   assign literal_adr_o            = bundle_q.lit;
   assign rd_sel1_o                = bundle_q.rs1;
   assign rd_sel2_o                = bundle_q.rs2;
   assign wr_sel_o                 = bundle_q.ws;
   assign rd_en1_o                 = bundle_q.re1;
   assign rd_en2_o                 = bundle_q.re2;
   assign wr_en_o                  = bundle_q.we;
   assign sel_reg_in_alu_decoder_o = bundle_q.sel;
   assign cnt_wr_en_o              = bundle_q.cnt;
   assign add_offset_o             = bundle_q.addo;
   assign stat_wr_en_o             = bundle_q.stw;
endmodule

// File: tb/tb_pipelined_decoder.sv
// Self-checking bench for pipelined_decoder: behavioural model + per-cycle compare,
// directed literal checks and a randomized phase. Follows DECODER_SCOREBOARD_EN.
module tb_pipelined_decoder;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [15:0] instruction = '0;
   logic [2:0]  status = '0;
   logic        wb_valid = 1'b0, stat_wb = 1'b0;
   logic [1:0]  wb_sel = '0;
   logic [4:0]  opcode_o;
   logic [7:0]  param_o, literal_adr_o;
   logic [1:0]  rd_sel1_o, rd_sel2_o, wr_sel_o;
   logic        rd_en1_o, rd_en2_o, wr_en_o, sel_o, cnt_wr_en_o, add_offset_o, stat_wr_en_o;

   int n_cmp = 0, n_bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   pipelined_decoder dut (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instruction_i(instruction), .status_i(status), .wb_valid_i(wb_valid),
      .wb_sel_i(wb_sel), .stat_wb_i(stat_wb), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .opcode_o(opcode_o), .param_o(param_o),
      .literal_adr_o(literal_adr_o), .rd_sel1_o(rd_sel1_o), .rd_sel2_o(rd_sel2_o),
      .wr_sel_o(wr_sel_o), .rd_en1_o(rd_en1_o), .rd_en2_o(rd_en2_o), .wr_en_o(wr_en_o),
      .sel_reg_in_alu_decoder_o(sel_o), .cnt_wr_en_o(cnt_wr_en_o),
      .add_offset_o(add_offset_o), .stat_wr_en_o(stat_wr_en_o)
   );

   typedef struct packed {
      logic [4:0] opc;
      logic [7:0] prm, lit;
      logic [1:0] rs1, rs2, ws;
      logic       re1, re2, we, sel, cnt, addo, stw;
   } exp_t;

   exp_t dut_b;
   assign dut_b = {opcode_o, param_o, literal_adr_o, rd_sel1_o, rd_sel2_o, wr_sel_o,
                   rd_en1_o, rd_en2_o, wr_en_o, sel_o, cnt_wr_en_o, add_offset_o, stat_wr_en_o};

   // Opcode classes straight from the instruction-set table.
   function automatic exp_t model_decode(input logic [15:0] ins, input logic [2:0] st);
      exp_t       e = '0;
      logic [4:0] o = ins[15:11];
      logic [1:0] a = ins[9:8];
      logic [1:0] b = ins[4:3];
      bit         alu2  = (o == 1) || (o == 2) || (o == 3) || (o == 4) || (o == 6);
      bit         notop = (o == 5);
      bit         sh    = (o == 7) || (o == 8);
      bit         val   = (o == 9);
      bit   [4:0] ct;
      ct[0] = st[2]; ct[1] = !st[2]; ct[2] = st[2]; ct[3] = st[1]; ct[4] = st[0];
      e.opc = o;
      e.prm = ins[7:0];
      e.re1 = alu2 || sh;
      e.re2 = alu2 || notop;
      e.we  = alu2 || notop || sh || val;
      e.sel = alu2 || notop || sh;
      e.stw = e.sel;
      e.rs1 = e.re1 ? a : 2'd0;
      e.rs2 = e.re2 ? b : 2'd0;
      e.ws  = e.we  ? a : 2'd0;
      if (o == 16) begin
         e.cnt = 1'b1;
         e.lit = ins[7:0];
      end
      if (o >= 17 && o <= 21) begin
         e.cnt  = ct[int'(o) - 17];
         e.addo = e.cnt;
         e.lit  = ins[7:0];
      end
      return e;
   endfunction

   bit   m_valid;
   exp_t m_b, cand;
   bit   m_stall, m_ready;
   bit [3:0] m_pend;
   bit   m_spend;

   always_comb begin
      cand    = model_decode(instruction, status);
      m_stall = 1'b0;
`ifdef DECODER_SCOREBOARD_EN
      m_stall = (cand.re1 && m_pend[cand.rs1]) || (cand.re2 && m_pend[cand.rs2]) ||
                (cand.opc >= 17 && cand.opc <= 21 && m_spend);
`endif
      m_ready = (!m_valid || out_ready) && !m_stall;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_b     <= '0;
         m_pend  <= '0;
         m_spend <= 1'b0;
      end else begin
         bit [3:0] p;
         bit       s;
         p = m_pend;
         s = m_spend;
         if (wb_valid) p[wb_sel] = 1'b0;
         if (stat_wb)  s = 1'b0;
         if (in_valid && m_ready) begin
            m_valid <= 1'b1;
            m_b     <= cand;
            if (cand.we)  p[cand.ws] = 1'b1;
            if (cand.stw) s = 1'b1;
         end else if (out_ready) begin
            m_valid <= 1'b0;
         end
         m_pend  <= p;
         m_spend <= s;
      end
   end

   task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("in_ready", 34'(in_ready), 34'(m_ready));
         chk("out_valid", 34'(out_valid), 34'(m_valid));
         if (m_valid) chk("bundle", 34'(dut_b), 34'(m_b));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      stat_wb   = 1'b1;
      wb_valid  = 1'b1;
      for (int r = 0; r < 4; r++) begin
         wb_sel = 2'(r);
         cyc();
      end
      wb_valid = 1'b0;
      stat_wb  = 1'b0;
   endtask

   initial begin
      #3;
      chk("reset_outputs", 34'(dut_b), 34'd0);
      chk("reset_valid", 34'(out_valid), 34'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;
      #1 chk("ready_after_reset", 34'(in_ready), 34'd1);

      // ADD op1=1 op2=2
      out_ready = 1'b1; in_valid = 1'b1; instruction = 16'h0910;
      cyc();
      in_valid = 1'b0;
      #1;
      chk("add_valid", 34'(out_valid), 34'd1);
      chk("add_rs1", 34'(rd_sel1_o), 34'd1);
      chk("add_rs2", 34'(rd_sel2_o), 34'd2);
      chk("add_ws", 34'(wr_sel_o), 34'd1);
      chk("add_stw", 34'(stat_wr_en_o), 34'd1);
      cyc();
      #1 chk("valid_clears", 34'(out_valid), 34'd0);

      // IFGT param=09: GT set, then Z only
      drain();
      in_valid = 1'b1; instruction = 16'hA809; status = 3'b001;
      cyc();
      status = 3'b100;
      #1;
      chk("ifgt_t_addo", 34'(add_offset_o), 34'd1);
      chk("ifgt_t_cnt", 34'(cnt_wr_en_o), 34'd1);
      chk("ifgt_t_lit", 34'(literal_adr_o), 34'h09);
      cyc();
      in_valid = 1'b0;
      #1;
      chk("ifgt_f_addo", 34'(add_offset_o), 34'd0);
      chk("ifgt_f_cnt", 34'(cnt_wr_en_o), 34'd0);

      // VAL A5 held under back-pressure, ADD queued behind it
      drain();
      out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h48A5;
      cyc();
      instruction = 16'h0910;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", 34'(in_ready), 34'd0);
         chk("bp_param", 34'(param_o), 34'hA5);
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      #1 chk("bp_next_opc", 34'(opcode_o), 34'd1);
      cyc();

`ifdef DECODER_SCOREBOARD_EN
      // VAL r3 then ADD r3,r1 waits for r3 writeback
      drain();
      in_valid = 1'b1; instruction = 16'h4B00;
      cyc();
      instruction = 16'h0B08;
      #1 chk("sb_stall0", 34'(in_ready), 34'd0);
      cyc();
      #1 chk("sb_stall1", 34'(in_ready), 34'd0);
      wb_valid = 1'b1; wb_sel = 2'd3;
      #1 chk("sb_stall_wb", 34'(in_ready), 34'd0);
      cyc();
      wb_valid = 1'b0;
      #1 chk("sb_release", 34'(in_ready), 34'd1);
      cyc();
      in_valid = 1'b0;
      #1 chk("sb_add_rs1", 34'(rd_sel1_o), 34'd3);
      // SUB then IFZ waits for status writeback
      drain();
      in_valid = 1'b1; instruction = 16'h1000;
      cyc();
      instruction = 16'h8800;
      #1 chk("sb_stat_stall", 34'(in_ready), 34'd0);
      stat_wb = 1'b1;
      cyc();
      stat_wb = 1'b0;
      #1 chk("sb_stat_release", 34'(in_ready), 34'd1);
      cyc();
      in_valid = 1'b0;
      #1 chk("sb_ifz_opc", 34'(opcode_o), 34'h11);
`else
      // SUB then IFZ goes back-to-back
      drain();
      in_valid = 1'b1; instruction = 16'h1000;
      cyc();
      instruction = 16'h8800;
      #1 chk("b2b_ready", 34'(in_ready), 34'd1);
      cyc();
      in_valid = 1'b0;
      #1 chk("b2b_ifz_opc", 34'(opcode_o), 34'h11);
`endif

      // Randomized traffic
      drain();
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if ($urandom_range(3) != 0) ins[15:11] = 5'($urandom_range(21));
         instruction = ins;
         in_valid    = ($urandom_range(9) < 7);
         out_ready   = ($urandom_range(9) < 7);
         status      = 3'($urandom);
         wb_valid    = ($urandom_range(3) == 0);
         wb_sel      = 2'($urandom);
         stat_wb     = ($urandom_range(3) == 0);
         cyc();
      end

      // Asynchronous reset while a bundle is held
      drain();
      out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h48A5;
      cyc();
      in_valid = 1'b0;
      #1 chk("pre_reset_valid", 34'(out_valid), 34'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 34'(dut_b), 34'd0);
      chk("async_reset_valid", 34'(out_valid), 34'd0);
      cyc();
      rst_n = 1'b1;
      #1 chk("ready_after_rerelease", 34'(in_ready), 34'd1);
      cyc();
      #1 chk("no_replay", 34'(out_valid), 34'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
